// File: rtl/noc_pkg.sv
// Shared definitions for the NoC router input-port blocks.
//  - clog2     : ceiling log2 with a floor of 1, used to size pointers and indices
//  - is_onehot : true when exactly one bit of a (zero-extended) select vector is set
//  - ERR_*     : bit positions inside the sticky error vector
package noc_pkg;

  localparam int ERR_OVF = 0;   // write to a full VC
  localparam int ERR_UDF = 1;   // read of an empty VC
  localparam int ERR_CNF = 2;   // select vector not one-hot
  localparam int ERR_W   = 3;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/vc_fifo_ctrl.sv
// Book-keeping for one virtual channel of the shared flit RAM.
// Holds the write/read pointers inside the VC's B-entry region, the
// occupancy counter and the registered status flags derived from it.
// Ports:
//  clk, reset   rising-edge clock, synchronous active-high reset
//  push, pop    accepted write / accepted read for this VC this cycle
//  wr_ptr       slot the next accepted write lands in
//  rd_ptr       slot the next accepted read comes from
//  not_empty    occupancy != 0
//  full         occupancy == B
//  almost_full  (B - occupancy) <= AF_TH
module vc_fifo_ctrl
  import noc_pkg::*;
#(
  parameter int B     = 4,
  parameter int AF_TH = 1,
  parameter int PW    = clog2(B)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic          not_empty,
  output logic          full,
  output logic          almost_full
);

  localparam logic [PW:0]   DEPTH    = (PW + 1)'(B);
  localparam logic [31:0]   AF_TH_U  = AF_TH;
  localparam logic          AF_RESET = (AF_TH >= B);

  logic [PW:0] cnt;
  logic [PW:0] cnt_nxt;
  logic [PW:0] free_nxt;

  // Simultaneous push and pop leave the occupancy unchanged.
  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop) begin
      cnt_nxt = cnt + 1'b1;
    end else if (pop && !push) begin
      cnt_nxt = cnt - 1'b1;
    end
    free_nxt = DEPTH - cnt_nxt;
  end

  // Pointers wrap for free because B is a power of two and PW = log2(B).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      not_empty   <= 1'b0;
      full        <= 1'b0;
      almost_full <= AF_RESET;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt         <= cnt_nxt;
      not_empty   <= (cnt_nxt != '0);
      full        <= (cnt_nxt == DEPTH);
      almost_full <= (32'(free_nxt) <= AF_TH_U);
    end
  end

endmodule

// File: rtl/flit_buffer_vc_credit.sv
// Multi-VC input flit buffer for a NoC router port.
// One RAM is split into V regions of B flits; each region is managed by a
// vc_fifo_ctrl instance. Reads are registered (one cycle latency) and every
// successful pop returns a credit pulse to the upstream router in the same
// cycle the flit shows on dout.
// Ports:
//  clk, reset      rising-edge clock, synchronous active-high reset
//  din             incoming flit
//  vc_num_wr       one-hot write VC select, qualified by wr_en
//  wr_en           write strobe
//  vc_num_rd       one-hot read VC select (allocator grant), qualified by rd_en
//  rd_en           read strobe
//  ssa_rd          one-hot speculative switch-allocation read
//  dout            last flit read, registered
//  dout_valid      dout was refreshed by a pop on the previous edge
//  vc_not_empty    per-VC occupancy != 0
//  vc_full         per-VC occupancy == B
//  vc_almost_full  per-VC free slots <= AF_TH
//  credit_out      per-VC one-cycle pulse aligned with dout_valid
//  err_flags       sticky {conflict, underflow, overflow}
module flit_buffer_vc_credit
  import noc_pkg::*;
#(
  parameter int V     = 4,
  parameter int B     = 4,
  parameter int Fw    = 32,
  parameter int AF_TH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Fw-1:0]    din,
  input  logic [V-1:0]     vc_num_wr,
  input  logic             wr_en,
  input  logic [V-1:0]     vc_num_rd,
  input  logic             rd_en,
  input  logic [V-1:0]     ssa_rd,
  output logic [Fw-1:0]    dout,
  output logic             dout_valid,
  output logic [V-1:0]     vc_not_empty,
  output logic [V-1:0]     vc_full,
  output logic [V-1:0]     vc_almost_full,
  output logic [V-1:0]     credit_out,
  output logic [ERR_W-1:0] err_flags
);

  localparam int PW    = clog2(B);
  localparam int IW    = clog2(V);
  localparam int AW    = IW + PW;
  localparam int DEPTH = V * B;

  logic [Fw-1:0]    mem [DEPTH];

  logic [V-1:0]     rd_vec;
  logic             wr_oh;
  logic             rd_oh;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [V-1:0]     push_p0;
  logic [V-1:0]     pop_p0;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [ERR_W-1:0] err_set;
  logic [PW-1:0]    wr_ptr [V];
  logic [PW-1:0]    rd_ptr [V];

  // Stage 0: decode selects, decide which write/pop is accepted.
  // A granted read and a speculative read naming the same VC merge into a
  // single pop because they are OR-ed into one vector before the check.
  always_comb begin
    rd_vec = (rd_en ? vc_num_rd : '0) | ssa_rd;
    wr_oh  = is_onehot(32'(vc_num_wr));
    rd_oh  = is_onehot(32'(rd_vec));

    wr_idx = '0;
    rd_idx = '0;
    for (int i = 0; i < V; i++) begin
      if (vc_num_wr[i]) wr_idx = IW'(i);
      if (rd_vec[i])    rd_idx = IW'(i);
    end

    // A write into a full VC is still accepted when that VC pops this cycle.
    for (int i = 0; i < V; i++) begin
      pop_p0[i]  = rd_oh & rd_vec[i] & vc_not_empty[i];
      push_p0[i] = wr_en & wr_oh & vc_num_wr[i] & (~vc_full[i] | pop_p0[i]);
    end

    // Region base v*B is a plain concatenation since B is a power of two.
    wr_addr = {wr_idx, wr_ptr[wr_idx]};
    rd_addr = {rd_idx, rd_ptr[rd_idx]};

    err_set          = '0;
    err_set[ERR_OVF] = wr_en & wr_oh & (|(vc_num_wr & vc_full & ~pop_p0));
    err_set[ERR_UDF] = rd_oh & (|(rd_vec & ~vc_not_empty));
    err_set[ERR_CNF] = (wr_en & ~wr_oh) | ((rd_vec != '0) & ~rd_oh);
  end

  for (genvar g = 0; g < V; g++) begin : g_vc
    vc_fifo_ctrl #(
      .B     (B),
      .AF_TH (AF_TH),
      .PW    (PW)
    ) u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .push        (push_p0[g]),
      .pop         (pop_p0[g]),
      .wr_ptr      (wr_ptr[g]),
      .rd_ptr      (rd_ptr[g]),
      .not_empty   (vc_not_empty[g]),
      .full        (vc_full[g]),
      .almost_full (vc_almost_full[g])
    );
  end

  // Flit storage carries no reset; stale contents are unreachable once the
  // per-VC pointers and counters are cleared.
  always_ff @(posedge clk) begin
    if (|push_p0) mem[wr_addr] <= din;
  end

  // Stage 1: registered read data, valid, credit and sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      credit_out <= '0;
      err_flags  <= '0;
    end else begin
      dout_valid <= |pop_p0;
      credit_out <= pop_p0;
      if (|pop_p0) dout <= mem[rd_addr];
      err_flags  <= err_flags | err_set;
    end
  end

endmodule
